// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode encodings, FSM state encoding and opcode helpers
// shared by the sequential ALU and its iterative engine.
// Optional divider is enabled by defining SEQ_ALU_DIV_EN.
package seq_alu_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'b0000;
  localparam opcode_t OP_SUB  = 4'b0001;
  localparam opcode_t OP_AND  = 4'b0100;
  localparam opcode_t OP_OR   = 4'b0101;
  localparam opcode_t OP_XOR  = 4'b0110;
  localparam opcode_t OP_MUL  = 4'b1000;
  localparam opcode_t OP_DIVU = 4'b1001;
  localparam opcode_t OP_BEQ  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } state_e;

  // True for opcodes handled by the multi-cycle engine in this build.
  function automatic logic is_iter_op(input opcode_t op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: iterative engine for the sequential ALU.
// Shift-add unsigned multiply (low WIDTH bits kept); with SEQ_ALU_DIV_EN
// defined, also an unsigned restoring divide returning the quotient.
// One iteration per clock; done pulses on the last iteration with the
// final value on result in the same cycle.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mul_acc_s;
`ifdef SEQ_ALU_DIV_EN
  // a_sh holds the divisor, b_sh shifts the dividend out and the quotient in,
  // acc holds the partial remainder.
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] rem_sub_s;
  logic             rem_ge_s;
`endif

  // Next-state logic: load on start, otherwise one multiply/divide step per cycle while busy.
  always_comb begin
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    done      = 1'b0;
    result    = {WIDTH{1'b0}};
    mul_acc_s = acc_q + (b_sh_q[0] ? a_sh_q : {WIDTH{1'b0}});
`ifdef SEQ_ALU_DIV_EN
    div_d     = div_q;
    rem_sh_s  = {acc_q, b_sh_q[WIDTH-1]};
    rem_ge_s  = (rem_sh_s >= {1'b0, a_sh_q});
    // Only used when rem_ge_s holds, so the true difference fits in WIDTH bits.
    rem_sub_s = rem_sh_s[WIDTH-1:0] - a_sh_q;
`endif
    if (start && is_iter_op(op)) begin
      busy_d = 1'b1;
      cnt_d  = {CNT_W{1'b0}};
      a_sh_d = a;
      b_sh_d = b;
      acc_d  = {WIDTH{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      div_d  = (op == OP_DIVU);
`endif
    end else if (busy_q) begin
      acc_d  = mul_acc_s;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      result = mul_acc_s;
`ifdef SEQ_ALU_DIV_EN
      if (div_q) begin
        a_sh_d = a_sh_q;
        if (rem_ge_s) begin
          acc_d  = rem_sub_s;
          b_sh_d = {b_sh_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d  = rem_sh_s[WIDTH-1:0];
          b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        end
        result = b_sh_d;
      end else begin
        result = mul_acc_s;
      end
`endif
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        done   = 1'b1;
        busy_d = 1'b0;
      end else begin
        done   = 1'b0;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Engine state registers with synchronous active-low reset (aborts any operation).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      a_sh_q <= {WIDTH{1'b0}};
      b_sh_q <= {WIDTH{1'b0}};
      acc_q  <= {WIDTH{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked, parametrised ALU. Single-cycle ADD/SUB/AND/OR/XOR/BEQ,
// multi-cycle MUL through seq_alu_iter, registered result and flags.
// Defining SEQ_ALU_DIV_EN adds DIVU (restoring divide, WIDTH+1 latency).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_err
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             pend_err_q, pend_err_d;

  logic             accept_s;
  logic             xfer_s;
  logic             iter_start_s;
  logic             iter_done_s;
  logic [WIDTH-1:0] iter_result_s;
  logic             div0_s;
  state_e           iter_state_s;

  logic             sub_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_carry_s;
  logic             alu_ovf_s;
  logic             alu_err_s;

  // Held low during reset so the producer never sees a spurious ready.
  assign in_ready     = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept_s     = in_valid && in_ready;
  assign xfer_s       = out_valid_q && out_ready;
  assign iter_start_s = accept_s && is_iter_op(in_op);

`ifdef SEQ_ALU_DIV_EN
  assign div0_s       = (in_op == OP_DIVU) && (in_b == {WIDTH{1'b0}});
  assign iter_state_s = (in_op == OP_DIVU) ? DIV : MUL;
`else
  assign div0_s       = 1'b0;
  assign iter_state_s = MUL;
`endif

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start_s),
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .done   (iter_done_s),
    .result (iter_result_s)
  );

  // Single-cycle datapath: add/sub at WIDTH+1 bits (MSB is carry), logic ops, compare, illegal trap.
  always_comb begin
    sub_s       = (in_op == OP_SUB);
    b_op_s      = sub_s ? ~in_b : in_b;
    sum_s       = {1'b0, in_a} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, sub_s};
    alu_res_s   = {WIDTH{1'b0}};
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    alu_err_s   = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB: begin
        alu_res_s   = sum_s[WIDTH-1:0];
        alu_carry_s = sum_s[WIDTH];
        alu_ovf_s   = (in_a[WIDTH-1] == b_op_s[WIDTH-1]) && (sum_s[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res_s = in_a & in_b;
      OP_OR:   alu_res_s = in_a | in_b;
      OP_XOR:  alu_res_s = in_a ^ in_b;
      OP_BEQ:  alu_res_s = {{(WIDTH-1){1'b0}}, (in_a == in_b)};
      default: alu_err_s = 1'b1;
    endcase
  end

  // FSM next state and output-register updates; fields only change when a new result lands.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    pend_err_d  = pend_err_q;
    if (xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (is_iter_op(in_op)) begin
            state_d    = iter_state_s;
            pend_err_d = div0_s;
          end else begin
            out_valid_d = 1'b1;
            res_d       = alu_res_s;
            zero_d      = (alu_res_s == {WIDTH{1'b0}});
            carry_d     = alu_carry_s;
            ovf_d       = alu_ovf_s;
            err_d       = alu_err_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        if (iter_done_s) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          res_d       = iter_result_s;
          zero_d      = (iter_result_s == {WIDTH{1'b0}});
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          err_d       = pend_err_q;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      pend_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      pend_err_q  <= pend_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;
  assign out_ovf    = ovf_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random stimulus for seq_alu, checked against a
// behavioural model written with plain arithmetic. DIVU cases are compiled
// in when SEQ_ALU_DIV_EN is defined.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         v;
    logic         e;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = 4'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zero;
  logic         out_carry;
  logic         out_ovf;
  logic         out_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .out_err    (out_err)
  );

  // Reference model: result, flags and latency from the opcode rules.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    logic [W:0] u;
    logic signed [W:0] s;
    m.res = '0; m.c = 1'b0; m.v = 1'b0; m.e = 1'b0; m.lat = 1;
    case (op)
      4'b0000: begin
        u = {1'b0, a} + {1'b0, b};
        m.res = u[W-1:0];
        m.c = u[W];
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        m.v = (s[W] != s[W-1]);
      end
      4'b0001: begin
        m.res = a - b;
        m.c = (a >= b);
        s = $signed({a[W-1], a}) - $signed({b[W-1], b});
        m.v = (s[W] != s[W-1]);
      end
      4'b0100: m.res = a & b;
      4'b0101: m.res = a | b;
      4'b0110: m.res = a ^ b;
      4'b1000: begin m.res = a * b; m.lat = W + 1; end
      4'b1010: m.res = (a == b) ? 64'd1 : 64'd0;
`ifdef SEQ_ALU_DIV_EN
      4'b1001: begin
        m.lat = W + 1;
        if (b == '0) begin m.res = '1; m.e = 1'b1; end
        else m.res = a / b;
      end
`endif
      default: m.e = 1'b1;
    endcase
    m.z = (m.res == '0);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0b, expected %0b", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    n_tests++;
    assert (obs == expv) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // Issue one request with out_ready high, measure latency and check every output field.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int guard;
    int lat;
    logic rdy_seen;
    e = model(op, a, b);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk1({tag, " accept"}, in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) rdy_seen = 1'b1;
    end while (!out_valid && lat < 200);
    chki({tag, " latency"}, lat, e.lat);
    if (e.lat > 1) chk1({tag, " busy ready"}, rdy_seen, 1'b0);
    chk({tag, " result"}, out_result, e.res);
    chk1({tag, " zero"}, out_zero, e.z);
    chk1({tag, " carry"}, out_carry, e.c);
    chk1({tag, " ovf"}, out_ovf, e.v);
    chk1({tag, " err"}, out_err, e.e);
  endtask

  initial begin
    exp_t e_and, e_or, e_xor, e_add;
    logic [W-1:0] ra, rb;
    logic [3:0] rop;
    int seen;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("reset in_ready", in_ready, 1'b0);
    chk1("reset out_valid", out_valid, 1'b0);
    chk("reset result", out_result, 64'd0);
    chk1("reset flags", out_zero | out_carry | out_ovf | out_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("post-reset in_ready", in_ready, 1'b1);

    // Directed vectors
    run_op("add wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add wrap const", out_result, 64'd0);
    run_op("sub ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1);
    chk("sub ovf const", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
    run_op("beq eq", OP_BEQ, 64'd5, 64'd5);
    chk("beq const", out_result, 64'd1);
    run_op("mul", OP_MUL, 64'd12345, 64'd678);
    chk("mul const", out_result, 64'd8369910);
    run_op("illegal f", 4'b1111, 64'd77, 64'd3);
    run_op("sub borrow", OP_SUB, 64'd3, 64'd9);
    run_op("add max pos", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
`ifdef SEQ_ALU_DIV_EN
    run_op("divu", OP_DIVU, 64'd100, 64'd7);
    chk("divu const", out_result, 64'd14);
    run_op("divu zero", OP_DIVU, 64'h1234, 64'd0);
    chk("divu zero const", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    run_op("op 1001 illegal", 4'b1001, 64'd100, 64'd7);
`endif

    // Back-to-back single-cycle ops, then a 3-cycle output stall
    e_and = model(OP_AND, 64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF);
    e_or  = model(OP_OR,  64'h1111_0000_2222_0000, 64'h0000_3333_0000_4444);
    e_xor = model(OP_XOR, 64'hAAAA_AAAA_5555_5555, 64'hFFFF_0000_FFFF_0000);
    e_add = model(OP_ADD, 64'd40, 64'd2);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = OP_AND; in_a = 64'hF0F0_1234_5678_9ABC; in_b = 64'h0FF0_FFFF_0000_FFFF;
    chk1("b2b and ready", in_ready, 1'b1);
    @(negedge clk);
    chk1("b2b and valid", out_valid, 1'b1);
    chk("b2b and result", out_result, e_and.res);
    chk1("b2b or ready", in_ready, 1'b1);
    in_op = OP_OR; in_a = 64'h1111_0000_2222_0000; in_b = 64'h0000_3333_0000_4444;
    @(negedge clk);
    chk1("b2b or valid", out_valid, 1'b1);
    chk("b2b or result", out_result, e_or.res);
    in_op = OP_XOR; in_a = 64'hAAAA_AAAA_5555_5555; in_b = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    chk("b2b xor result", out_result, e_xor.res);
    out_ready = 1'b0;
    in_op = OP_ADD; in_a = 64'd40; in_b = 64'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("stall valid", out_valid, 1'b1);
      chk("stall result", out_result, e_xor.res);
      chk1("stall in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1("post-stall valid", out_valid, 1'b1);
    chk("post-stall add", out_result, e_add.res);
    in_valid = 1'b0;
    @(negedge clk);
    chk1("drained valid", out_valid, 1'b0);

    // Reset in the middle of a MUL
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_MUL; in_a = 64'd999; in_b = 64'd1001;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1("mid-mul reset valid", out_valid, 1'b0);
    chk("mid-mul reset result", out_result, 64'd0);
    chk1("mid-mul reset flags", out_zero | out_carry | out_ovf | out_err, 1'b0);
    chk1("mid-mul reset in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("after abort in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chki("aborted mul no result", seen, 0);
    run_op("add after reset", OP_ADD, 64'd2, 64'd3);
    chk("add 2+3 const", out_result, 64'd5);

    // Random operations over the full opcode space
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: rb = '0;
        2: rb = 64'($urandom_range(1, 300));
        default: rb = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 5) == 0) ra = 64'h8000_0000_0000_0000;
      run_op($sformatf("rand%0d op%0h", i, rop), rop, ra, rb);
    end

    @(negedge clk);
    out_ready = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
